fwrisc_mds_param: RTL and testbench
===================================

FWRISC_MDS_PARAM -- requirements
Module: fwrisc_mds_param

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8, 16, 32, 64 (power of two).
REQ-002 Port clk  input  1  clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-low.
REQ-004 Port in_valid  input  1  request valid.
REQ-005 Port in_ready  output  1  unit can accept request.
REQ-006 Port in_op  input  4  operation code (REQ-010).
REQ-007 Port in_a, in_b  input  XLEN each  operands; shift amount = in_b[log2(XLEN)-1:0].
REQ-008 Port out_valid  output  1  result valid; out_ready  input  1  consumer accepts; out_data  output  XLEN  result.
REQ-009 Port busy  output  1  high in any state other than IDLE.

Function
REQ-010 Opcodes SHALL be 0 SLL, 1 SRL, 2 SRA, 3 MUL, 4 MULH (s*s), 5 MULHSU (s*u), 6 MULHU (u*u), 7 DIV, 8 DIVU, 9 REM, 10 REMU; codes 11-15 are illegal and return 0.
REQ-011 FSM SHALL have states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-012 Accept occurs when in_valid && in_ready; operands, op and shift amount are registered; IDLE->RUN.
REQ-013 RUN: serial shift one bit/cycle; shift amount n gives RUN for n cycles then DONE (n=0: 1 cycle).
REQ-014 RUN: MUL* radix-2 shift-add over 2*XLEN-bit product, exactly XLEN cycles; MUL returns low half, MULH/MULHSU/MULHU return the high half with correct signedness.
REQ-015 RUN: DIV*/REM* restoring division on magnitudes, exactly XLEN cycles; quotient sign = sign(a) XOR sign(b), remainder sign = sign(a) (signed ops only).
REQ-016 Divide by zero SHALL skip RUN (accept->DONE next cycle): quotient all-ones, remainder = in_a.
REQ-017 Signed overflow (a = most-negative, b = -1) SHALL skip RUN: DIV returns a, REM returns 0.
REQ-018 Illegal opcode SHALL skip RUN; out_data = 0.
REQ-019 DONE holds out_data stable and out_valid high until out_ready; on out_valid && out_ready, DONE->IDLE, same cycle in_ready stays low (no accept on the handshake cycle).
REQ-020 Inputs other than in_valid are don't-care outside the accept cycle; changes SHALL not affect an operation in progress.
REQ-021 Total latency accept->out_valid: shift n+1, MUL*/DIV* XLEN+1, special cases 1 cycle.

Reset
REQ-022 rst low at any rising edge, including mid-RUN or in DONE, SHALL force IDLE next cycle: out_valid 0, busy 0, in_ready 1, out_data 0; the pending operation is discarded.
REQ-023 All internal datapath registers SHALL be reset, so both instances of a two-copy miter start identically.

Configuration
REQ-024 Macro FWRISC_MDS_FAST_SHIFT_EN defined: SLL/SRL/SRA use a barrel shifter, skip RUN, latency 1 for any shift amount.
REQ-025 Macro undefined: serial shifting per REQ-013; MUL*/DIV* behaviour identical in both builds.

Verification (XLEN=32)
REQ-026 SRA a=0x80000000 b=4, out_ready=1 -> out_data 0xF8000000, out_valid 5 cycles after accept (1 cycle with macro).
REQ-027 MUL a=0xFFFFFFFE b=3 -> 0xFFFFFFFA; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000002; each 33 cycles.
REQ-028 DIV a=0xFFFFFFF9 b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=5 b=0 -> 0xFFFFFFFF, REMU -> 5 at 1 cycle.
REQ-029 DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000 at 1 cycle; REM -> 0.
REQ-030 Backpressure: result in DONE, out_ready low 5 cycles -> out_data/out_valid stable, in_ready 0, new in_valid ignored; out_ready high -> IDLE next cycle.
REQ-031 MUL accepted, rst low at RUN cycle 10 -> next cycle out_valid 0, busy 0, in_ready 1, out_data 0; no result ever emitted.

Source files
------------

// File: rtl/fwrisc_mds_param.sv
// fwrisc_mds_param: multi-cycle shift / multiply / divide unit.
// One request at a time: IDLE accepts, RUN iterates one bit per cycle, DONE
// holds the result until the consumer takes it.
// Build option: define FWRISC_MDS_FAST_SHIFT_EN to replace the serial shifter
// with a single-cycle barrel shifter (multiply/divide are unaffected).
module fwrisc_mds_param #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_SLL    = 4'd0;
  localparam logic [3:0] OP_SRL    = 4'd1;
  localparam logic [3:0] OP_SRA    = 4'd2;
  localparam logic [3:0] OP_MUL    = 4'd3;
  localparam logic [3:0] OP_MULH   = 4'd4;
  localparam logic [3:0] OP_MULHSU = 4'd5;
  localparam logic [3:0] OP_MULHU  = 4'd6;
  localparam logic [3:0] OP_DIV    = 4'd7;
  localparam logic [3:0] OP_DIVU   = 4'd8;
  localparam logic [3:0] OP_REM    = 4'd9;
  localparam logic [3:0] OP_REMU   = 4'd10;

  logic [1:0]        state;
  logic [3:0]        op_r;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   mag_r;   // multiplicand (MUL*) or divisor (DIV*) magnitude
  logic [2*XLEN-1:0] acc;     // product / {remainder, quotient} / shift value
  logic              neg_r;   // negate product or quotient at the end
  logic              rneg_r;  // negate remainder at the end
  logic [XLEN-1:0]   res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = res;

  logic accept;
  assign accept = in_valid && in_ready;

  // Accept-time decode: operand magnitudes, special cases and their results.
  logic            is_shift, is_mul, is_div, illegal, div0, ovf, skip;
  logic            a_sgn, b_sgn;
  logic [XLEN-1:0] mag_a, mag_b, skip_res;
  logic [SW-1:0]   sh_amt;

  // Classify the incoming request and precompute single-cycle results.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    is_shift = (in_op <= OP_SRA);
    is_mul   = (in_op >= OP_MUL) && (in_op <= OP_MULHU);
    is_div   = (in_op >= OP_DIV) && (in_op <= OP_REMU);
    illegal  = (in_op > OP_REMU);
    sh_amt   = in_b[SW-1:0];
    a_sgn    = in_a[XLEN-1] && ((in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                                (in_op == OP_DIV)  || (in_op == OP_REM));
    b_sgn    = in_b[XLEN-1] && ((in_op == OP_MULH) || (in_op == OP_DIV) ||
                                (in_op == OP_REM));
    mag_a    = a_sgn ? -in_a : in_a;
    mag_b    = b_sgn ? -in_b : in_b;
    div0     = is_div && (in_b == '0);
    ovf      = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
               (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
    skip     = 1'b0;
    skip_res = '0;
    if (illegal) begin
      skip = 1'b1;
    end else if (div0) begin
      skip     = 1'b1;
      skip_res = ((in_op == OP_DIV) || (in_op == OP_DIVU)) ? '1 : in_a;
    end else if (ovf) begin
      skip     = 1'b1;
      skip_res = (in_op == OP_DIV) ? in_a : '0;
    end else if (is_shift) begin
`ifdef FWRISC_MDS_FAST_SHIFT_EN
      skip = 1'b1;
      case (in_op)
        OP_SLL:  skip_res = in_a << sh_amt;
        OP_SRL:  skip_res = in_a >> sh_amt;
        default: skip_res = $unsigned($signed(in_a) >>> sh_amt);
      endcase
`else
      // A zero shift amount needs no iteration: the result is in_a itself.
      skip     = (sh_amt == '0);
      skip_res = in_a;
`endif
    end
  end

  // One iteration of the running operation, plus the final result it yields.
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN:0]     sum, rsh, diff;
  logic [XLEN-1:0]   quo, rem, fin;

  // Single-bit step for shift, shift-add multiply and restoring divide.
  always_comb begin
    acc_step = acc;
    sum      = '0;
    rsh      = '0;
    diff     = '0;
    case (op_r)
      OP_SLL: acc_step[XLEN-1:0] = {acc[XLEN-2:0], 1'b0};
      OP_SRL: acc_step[XLEN-1:0] = {1'b0, acc[XLEN-1:1]};
      OP_SRA: acc_step[XLEN-1:0] = {acc[XLEN-1], acc[XLEN-1:1]};
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_r} : '0);
        acc_step = {sum, acc[XLEN-1:1]};
      end
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
        // Remainder stays below the divisor, so the shifted value fits XLEN+1
        // bits and diff[XLEN] is a clean borrow flag.
        rsh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff = rsh - {1'b0, mag_r};
        if (!diff[XLEN]) acc_step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else             acc_step = {rsh[XLEN-1:0],  acc[XLEN-2:0], 1'b0};
      end
      default: acc_step = acc;
    endcase
    prod = neg_r  ? -acc_step : acc_step;
    quo  = neg_r  ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = rneg_r ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_r)
      OP_SLL, OP_SRL, OP_SRA:        fin = acc_step[XLEN-1:0];
      OP_MUL:                        fin = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fin = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fin = quo;
      OP_REM, OP_REMU:               fin = rem;
      default:                       fin = '0;
    endcase
  end

  // Control FSM and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: datapath registers are reset as well as control, so two copies
      // of the unit start bit-identical and out_data reads 0 after reset.
      state  <= IDLE;
      op_r   <= '0;
      cnt    <= '0;
      mag_r  <= '0;
      acc    <= '0;
      neg_r  <= 1'b0;
      rneg_r <= 1'b0;
      res    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r <= in_op;
            if (skip) begin
              res   <= skip_res;
              state <= DONE;
            end else begin
              state <= RUN;
              if (is_shift) begin
                acc    <= {{XLEN{1'b0}}, in_a};
                cnt    <= CW'(sh_amt);
                neg_r  <= 1'b0;
                rneg_r <= 1'b0;
              end else if (is_mul) begin
                mag_r  <= mag_a;
                acc    <= {{XLEN{1'b0}}, mag_b};
                cnt    <= CW'(XLEN);
                neg_r  <= a_sgn ^ b_sgn;
                rneg_r <= 1'b0;
              end else begin
                mag_r  <= mag_b;
                acc    <= {{XLEN{1'b0}}, mag_a};
                cnt    <= CW'(XLEN);
                neg_r  <= a_sgn ^ b_sgn;
                rneg_r <= a_sgn;
              end
            end
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            res   <= fin;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fwrisc_mds_param.sv
// Directed bench for fwrisc_mds_param at XLEN=32. Inputs are driven and
// outputs sampled on the falling edge; latency counts falling edges after the
// accepting rising edge until out_valid is seen.
module tb_fwrisc_mds_param;

  localparam int XLEN = 32;

  localparam logic [3:0] OP_SLL    = 4'd0;
  localparam logic [3:0] OP_SRL    = 4'd1;
  localparam logic [3:0] OP_SRA    = 4'd2;
  localparam logic [3:0] OP_MUL    = 4'd3;
  localparam logic [3:0] OP_MULH   = 4'd4;
  localparam logic [3:0] OP_MULHSU = 4'd5;
  localparam logic [3:0] OP_MULHU  = 4'd6;
  localparam logic [3:0] OP_DIV    = 4'd7;
  localparam logic [3:0] OP_DIVU   = 4'd8;
  localparam logic [3:0] OP_REM    = 4'd9;
  localparam logic [3:0] OP_REMU   = 4'd10;

`ifdef FWRISC_MDS_FAST_SHIFT_EN
  localparam int LAT_SRA4  = 1;
  localparam int LAT_SLL31 = 1;
  localparam int LAT_SRL5  = 1;
`else
  localparam int LAT_SRA4  = 5;
  localparam int LAT_SLL31 = 32;
  localparam int LAT_SRL5  = 6;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      in_op = '0;
  logic [XLEN-1:0] in_a = '0;
  logic [XLEN-1:0] in_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_data;
  logic            busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fwrisc_mds_param #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request for one rising edge, then scramble the inputs.
  task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(negedge clk);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = 4'd15;
    in_a     = ~a;
    in_b     = ~b;
  endtask

  // Falling edges after accept until out_valid; 0 means the bound expired.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    check({tag, " in_ready_hs"}, in_ready, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " valid_after_hs"}, out_valid, 1'b0);
    check({tag, " in_ready_after_hs"}, in_ready, 1'b1);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [XLEN-1:0] a,
                     input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int exp_lat);
    int lat;
    issue(op, a, b);
    wait_out(lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " data"}, out_data, exp);
    if (lat != 0) handshake(tag);
  endtask

  initial begin
    int  lat;
    logic seen;

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_data", out_data, 32'h0);

    // Shifts.
    run("sra_neg_4",  OP_SRA, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, LAT_SRA4);
    run("sll_31",     OP_SLL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, LAT_SLL31);
    run("srl_hi_amt", OP_SRL, 32'hF000_0000, 32'h0000_0025, 32'h0780_0000, LAT_SRL5);

    // Multiplies.
    run("mul",        OP_MUL,    32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 33);
    run("mulh",       OP_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33);
    run("mulhu",      OP_MULHU,  32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 33);
    run("mulhsu_neg", OP_MULHSU, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33);
    run("mulhsu_pos", OP_MULHSU, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 33);

    // Divides.
    run("div_neg",    OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
    run("rem_neg",    OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
    run("div_negb",   OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run("rem_negb",   OP_REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run("divu",       OP_DIVU, 32'd100,       32'd7,         32'd14,        33);
    run("remu",       OP_REMU, 32'd100,       32'd7,         32'd2,         33);

    // Special cases, all one cycle.
    run("divu_by0",   OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run("remu_by0",   OP_REMU, 32'd5,         32'd0,         32'd5,         1);
    run("div_by0",    OP_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1);
    run("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run("illegal",    4'd11,   32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1);

    // Backpressure: result held while out_ready is low; new requests ignored.
    issue(OP_MUL, 32'd6, 32'd7);
    wait_out(lat);
    check("bp latency", lat, 33);
    check("bp data", out_data, 32'd42);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_op    = OP_SLL;
      in_a     = 32'h1;
      in_b     = 32'h1;
      @(negedge clk);
      check("bp hold valid", out_valid, 1'b1);
      check("bp hold data", out_data, 32'd42);
      check("bp hold in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    check("bp hs in_ready", in_ready, 1'b0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp after valid", out_valid, 1'b0);
    check("bp after busy", busy, 1'b0);
    check("bp after in_ready", in_ready, 1'b1);

    // Reset during RUN discards the pending multiply.
    issue(OP_MUL, 32'h0000_1234, 32'h0000_5678);
    repeat (10) @(negedge clk);
    check("rst_mid busy before", busy, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst_mid out_valid", out_valid, 1'b0);
    check("rst_mid busy", busy, 1'b0);
    check("rst_mid in_ready", in_ready, 1'b1);
    check("rst_mid out_data", out_data, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("rst_mid no result", seen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
